// File: rtl/jalu_pkg.sv
// ---------------------------------------------------------------------------
// jalu_pkg
// Shared definitions for the 8-bit ALU and the blocks that sequence it.
//   - ALU op-select codes (3 bits) as driven on balu_op.
//   - WIDTH: the ALU / operand width.
//   - State encoding for the jmul_seq shift-and-add controller.
// ---------------------------------------------------------------------------
package jalu_pkg;

    localparam int WIDTH = 8;

    // ALU op-select codes
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    // jmul_seq controller states
    typedef logic [2:0] jmul_state_t;

    localparam jmul_state_t ST_IDLE = 3'd0;
    localparam jmul_state_t ST_ADD  = 3'd1;
    localparam jmul_state_t ST_SHH  = 3'd2;
    localparam jmul_state_t ST_SHL  = 3'd3;
    localparam jmul_state_t ST_DONE = 3'd4;

endpackage

// File: rtl/jmul_seq.sv
// ---------------------------------------------------------------------------
// jmul_seq
// Multi-cycle 8x8 unsigned shift-and-add multiplier controller. It owns no
// arithmetic: each step drives the external combinational ALU (ADD or SHR)
// and captures its result at the next clock edge. One multiply iteration is
// three states (ADD, SHH, SHL); eight iterations give the 16-bit product in
// {bphi, bplo}.
//
// Handshake: wstart is only looked at while wready=1 (state IDLE). An
// accepted start latches bmcand/bmplier. wdone is a one-cycle pulse while the
// final product is held in {bphi, bplo}; the product stays there until the
// next accepted start.
//
// Ports:
//   wclk, wrst_n      clock (rising edge), async active-low reset
//   wstart            start request
//   bmcand, bmplier   operands, latched on accepted start
//   wready, wdone     idle flag, product-valid pulse
//   bphi, bplo        product high / low byte
//   balu_a, balu_b    ALU operands
//   walu_ci, balu_op  ALU carry-in and op select
//   balu_c, walu_co   ALU result and carry-out
//
// Optional build macro:
//   JMUL_EARLY_EXIT_EN  a start with either operand zero skips the iteration
//                       sequence and goes straight to DONE with a zero
//                       product; no ALU ops are issued for it.
// ---------------------------------------------------------------------------
module jmul_seq
    import jalu_pkg::*;
#(
    parameter int WIDTH = jalu_pkg::WIDTH
) (
    input  logic       wclk,
    input  logic       wrst_n,
    input  logic       wstart,
    input  logic [7:0] bmcand,
    input  logic [7:0] bmplier,
    output logic       wready,
    output logic       wdone,
    output logic [7:0] bphi,
    output logic [7:0] bplo,
    output logic [7:0] balu_a,
    output logic [7:0] balu_b,
    output logic       walu_ci,
    output logic [2:0] balu_op,
    input  logic [7:0] balu_c,
    input  logic       walu_co
);

    localparam int ITER = WIDTH;
    localparam int CW   = $clog2(ITER);

    generate
        if (WIDTH != 8) begin : g_width_check
            $error("jmul_seq: only WIDTH=8 is supported");
        end
    endgenerate

    jmul_state_t   state;
    logic [7:0]    mcand;
    logic          c;       // carry between ADD -> SHH -> SHL
    logic [CW-1:0] cnt;
    logic          skip;    // accepted start needs no iterations

`ifdef JMUL_EARLY_EXIT_EN
    assign skip = (bmcand == 8'd0) || (bmplier == 8'd0);
`else
    assign skip = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Sequencing and partial-product registers
    // -----------------------------------------------------------------------
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= ST_IDLE;
            mcand <= 8'd0;
            c     <= 1'b0;
            cnt   <= '0;
            bphi  <= 8'd0;
            bplo  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wstart) begin
                        mcand <= bmcand;
                        bphi  <= 8'd0;
                        cnt   <= '0;
                        c     <= 1'b0;
                        if (skip) begin
                            bplo  <= 8'd0;
                            state <= ST_DONE;
                        end else begin
                            // multiplier sits in the low byte and is consumed
                            // LSB-first as the product shifts in from above
                            bplo  <= bmplier;
                            state <= ST_ADD;
                        end
                    end
                end
                ST_ADD: begin
                    // the 9th bit of the sum is kept so the following SHR
                    // brings it back in as the new MSB
                    if (bplo[0]) begin
                        bphi <= balu_c;
                        c    <= walu_co;
                    end else begin
                        c    <= 1'b0;
                    end
                    state <= ST_SHH;
                end
                ST_SHH: begin
                    bphi  <= balu_c;
                    c     <= walu_co;   // bit shifted out of the high byte
                    state <= ST_SHL;
                end
                ST_SHL: begin
                    bplo <= balu_c;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_ADD;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Handshake and ALU drive, decoded from the current state
    // -----------------------------------------------------------------------
    always_comb begin
        wready  = (state == ST_IDLE);
        wdone   = (state == ST_DONE);
        balu_a  = 8'd0;
        balu_b  = 8'd0;
        walu_ci = 1'b0;
        balu_op = OP_ADD;
        case (state)
            ST_ADD: begin
                balu_a  = bphi;
                balu_b  = mcand;
                walu_ci = 1'b0;
                balu_op = OP_ADD;
            end
            ST_SHH: begin
                balu_a  = bphi;
                walu_ci = c;
                balu_op = OP_SHR;
            end
            ST_SHL: begin
                balu_a  = bplo;
                walu_ci = c;
                balu_op = OP_SHR;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_jmul_seq.sv
// ---------------------------------------------------------------------------
// tb_jmul_seq
// Directed bench for jmul_seq. A behavioural 8-bit ALU (ADD, SHR) is attached
// to the balu_* ports. Inputs are driven and outputs sampled on the falling
// edge. Sample index j counts falling edges after the accepting rising edge
// E0, so sample j observes the interval between E(j) and E(j+1).
// ---------------------------------------------------------------------------
module tb_jmul_seq;
    import jalu_pkg::*;

    logic       wclk;
    logic       wrst_n;
    logic       wstart;
    logic [7:0] bmcand;
    logic [7:0] bmplier;
    logic       wready;
    logic       wdone;
    logic [7:0] bphi;
    logic [7:0] bplo;
    logic [7:0] balu_a;
    logic [7:0] balu_b;
    logic       walu_ci;
    logic [2:0] balu_op;
    logic [7:0] balu_c;
    logic       walu_co;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] op_log [0:39];
    logic       ci_log [0:39];

    jmul_seq dut (
        .wclk    (wclk),
        .wrst_n  (wrst_n),
        .wstart  (wstart),
        .bmcand  (bmcand),
        .bmplier (bmplier),
        .wready  (wready),
        .wdone   (wdone),
        .bphi    (bphi),
        .bplo    (bplo),
        .balu_a  (balu_a),
        .balu_b  (balu_b),
        .walu_ci (walu_ci),
        .balu_op (balu_op),
        .balu_c  (balu_c),
        .walu_co (walu_co)
    );

    // ---------------- clock ----------------
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // ---------------- external ALU model ----------------
    always_comb begin
        balu_c  = 8'd0;
        walu_co = 1'b0;
        case (balu_op)
            OP_ADD: {walu_co, balu_c} = {1'b0, balu_a} + {1'b0, balu_b} + {8'd0, walu_ci};
            OP_SHR: begin
                balu_c  = {walu_ci, balu_a[7:1]};
                walu_co = balu_a[0];
            end
            default: begin
            end
        endcase
    end

    // ---------------- driver ----------------
    // Issues one start and observes 30 samples (j = 0..29).
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           output logic [15:0] prod, output int done_at,
                           output int n_done, output int rdy_low);
        @(negedge wclk);
        bmcand  = a;
        bmplier = b;
        wstart  = 1'b1;
        @(posedge wclk);            // E0
        @(negedge wclk);
        wstart  = 1'b0;
        prod    = 16'hxxxx;
        done_at = -1;
        n_done  = 0;
        rdy_low = 0;
        for (int j = 0; j < 30; j++) begin
            if (j > 0) @(negedge wclk);
            if (wdone) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = j;
                    prod    = {bphi, bplo};
                end
            end
            if (!wready) rdy_low++;
            op_log[j] = balu_op;
            ci_log[j] = walu_ci;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        wrst_n  = 1'b0;
        wstart  = 1'b0;
        bmcand  = 8'd0;
        bmplier = 8'd0;
        #1;
        n_cmp++; if (wready !== 1'b1) begin n_bad++; $display("FAIL reset_wready got=%b want=1", wready); end
        n_cmp++; if (wdone !== 1'b0) begin n_bad++; $display("FAIL reset_wdone got=%b want=0", wdone); end
        n_cmp++; if ({bphi, bplo} !== 16'h0000) begin n_bad++; $display("FAIL reset_product got=%h want=0000", {bphi, bplo}); end
        n_cmp++; if ({balu_a, balu_b, walu_ci, balu_op} !== 20'h0) begin n_bad++;
            $display("FAIL reset_alu got a=%h b=%h ci=%b op=%0d want all 0", balu_a, balu_b, walu_ci, balu_op); end
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [15:0] p; int d, n, r;
        run_mul(8'd13, 8'd11, p, d, n, r);
        n_cmp++; if (p !== 16'h008F) begin n_bad++; $display("FAIL basic_product got=%h want=008f", p); end
        n_cmp++; if (d !== 24) begin n_bad++; $display("FAIL basic_done_at got=%0d want=24", d); end
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL basic_done_pulses got=%0d want=1", n); end
        n_cmp++; if (r !== 25) begin n_bad++; $display("FAIL basic_ready_low got=%0d want=25", r); end
    endtask

    task automatic test_carry;
        logic [15:0] p; int d, n, r;
        run_mul(8'hFF, 8'hFF, p, d, n, r);
        n_cmp++; if (p !== 16'hFE01) begin n_bad++; $display("FAIL carry_ff_ff got=%h want=fe01", p); end
        run_mul(8'h80, 8'h02, p, d, n, r);
        n_cmp++; if (p !== 16'h0100) begin n_bad++; $display("FAIL carry_80_02 got=%h want=0100", p); end
        n_cmp++; if (d !== 24) begin n_bad++; $display("FAIL carry_done_at got=%0d want=24", d); end
    endtask

    task automatic test_op_trace;
        logic [15:0] p; int d, n, r; int op_bad, ci_bad;
        logic [2:0] want;
        run_mul(8'd1, 8'd1, p, d, n, r);
        op_bad = 0;
        ci_bad = 0;
        for (int j = 0; j < 30; j++) begin
            want = (j < 24 && (j % 3) != 0) ? OP_SHR : OP_ADD;
            if (op_log[j] !== want) op_bad++;
            if (j < 24 && (j % 3) == 0 && ci_log[j] !== 1'b0) ci_bad++;
        end
        n_cmp++; if (op_bad !== 0) begin n_bad++; $display("FAIL op_trace_ops got=%0d wrong samples want=0", op_bad); end
        n_cmp++; if (ci_bad !== 0) begin n_bad++; $display("FAIL op_trace_add_ci got=%0d nonzero want=0", ci_bad); end
        n_cmp++; if (p[15:8] !== 8'h00) begin n_bad++; $display("FAIL op_trace_bphi got=%h want=00", p[15:8]); end
        n_cmp++; if (p[7:0] !== 8'h01) begin n_bad++; $display("FAIL op_trace_bplo got=%h want=01", p[7:0]); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] p1, p2; int d1, d2, n; logic rdy25;
        p1 = 16'hxxxx; p2 = 16'hxxxx; d1 = -1; d2 = -1; n = 0; rdy25 = 1'bx;
        @(negedge wclk);
        bmcand  = 8'd7;
        bmplier = 8'd9;
        wstart  = 1'b1;
        @(posedge wclk);            // E0
        @(negedge wclk);
        bmcand  = 8'd3;             // must be ignored until the controller is idle again
        bmplier = 8'd5;
        for (int j = 0; j < 60; j++) begin
            if (j > 0) @(negedge wclk);
            if (wdone) begin
                n++;
                if (d1 < 0) begin d1 = j; p1 = {bphi, bplo}; end
                else if (d2 < 0) begin d2 = j; p2 = {bphi, bplo}; end
            end
            if (j == 25) rdy25 = wready;
            if (j == 26) wstart = 1'b0;
        end
        wstart = 1'b0;
        n_cmp++; if (p1 !== 16'h003F) begin n_bad++; $display("FAIL b2b_first_product got=%h want=003f", p1); end
        n_cmp++; if (d1 !== 24) begin n_bad++; $display("FAIL b2b_first_done_at got=%0d want=24", d1); end
        n_cmp++; if (rdy25 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_e25 got=%b want=1", rdy25); end
        n_cmp++; if (p2 !== 16'h000F) begin n_bad++; $display("FAIL b2b_second_product got=%h want=000f", p2); end
        n_cmp++; if (d2 !== 50) begin n_bad++; $display("FAIL b2b_second_done_at got=%0d want=50", d2); end
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL b2b_done_pulses got=%0d want=2", n); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] p; int d, n, r;
        @(negedge wclk);
        bmcand  = 8'hFF;
        bmplier = 8'hFF;
        wstart  = 1'b1;
        @(posedge wclk);            // E0
        @(negedge wclk);
        wstart  = 1'b0;
        repeat (12) @(posedge wclk);
        #2;
        n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got=%b want=0", wready); end
        wrst_n = 1'b0;
        #1;
        n_cmp++; if (wready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_wready got=%b want=1", wready); end
        n_cmp++; if ({bphi, bplo} !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_product got=%h want=0000", {bphi, bplo}); end
        n_cmp++; if ({wdone, balu_a, balu_b, walu_ci, balu_op} !== 21'h0) begin n_bad++;
            $display("FAIL rst_mid_outputs got done=%b a=%h b=%h ci=%b op=%0d want all 0", wdone, balu_a, balu_b, walu_ci, balu_op); end
        @(negedge wclk);
        wrst_n = 1'b1;
        run_mul(8'd2, 8'd3, p, d, n, r);
        n_cmp++; if (p !== 16'h0006) begin n_bad++; $display("FAIL rst_mid_after_product got=%h want=0006", p); end
        n_cmp++; if (d !== 24) begin n_bad++; $display("FAIL rst_mid_after_done_at got=%0d want=24", d); end
    endtask

    task automatic test_zero;
        logic [15:0] p; int d, n, r; int op_nz;
        run_mul(8'd0, 8'd200, p, d, n, r);
        op_nz = 0;
        for (int j = 0; j < 30; j++) if (op_log[j] !== OP_ADD) op_nz++;
        n_cmp++; if (p !== 16'h0000) begin n_bad++; $display("FAIL zero_product got=%h want=0000", p); end
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL zero_done_pulses got=%0d want=1", n); end
`ifdef JMUL_EARLY_EXIT_EN
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL zero_done_at got=%0d want=0", d); end
        n_cmp++; if (op_nz !== 0) begin n_bad++; $display("FAIL zero_alu_ops got=%0d shr samples want=0", op_nz); end
`else
        n_cmp++; if (d !== 24) begin n_bad++; $display("FAIL zero_done_at got=%0d want=24", d); end
        n_cmp++; if (op_nz !== 16) begin n_bad++; $display("FAIL zero_alu_ops got=%0d shr samples want=16", op_nz); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_op_trace();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // safety bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
